dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit storage words; power of two, 4..4096.
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response; range 0..15.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low. Ports are clk and resetn.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  byte-lane enables; bit n enables byte n (little-endian).
REQ-012 rsp_valid  output  1  response is available.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access faulted.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE. A request is accepted on any edge where req_valid and req_ready are both 1.
REQ-018 On accept, the block SHALL latch write, addr, wdata and wstrb. It SHALL go to WAIT with counter = LATENCY, or straight to RESP if LATENCY = 0.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 1.
REQ-020 rsp_valid SHALL first be 1 exactly LATENCY+1 cycles after the accept edge. It SHALL stay 1, with rsp_rdata and rsp_err stable, until rsp_ready is 1.
REQ-021 On the edge where rsp_valid and rsp_ready are both 1, the FSM SHALL return to IDLE. A new request SHALL NOT be accepted in that same cycle, so at most one transaction is outstanding.
REQ-022 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-023 An address is out of range when req_addr >= 4*DEPTH_WORDS. An out-of-range access SHALL give rsp_err=1, rsp_rdata=0 and no storage change.
REQ-024 Stores SHALL commit on the edge entering RESP, updating only the lanes enabled by wstrb. wstrb=0 SHALL complete with no change and rsp_err=0.
REQ-025 Loads SHALL sample the full word on the edge entering RESP, so they see every earlier completed store.
REQ-026 req_valid deasserting while the block is not in IDLE SHALL have no effect.
REQ-027 Request inputs outside IDLE SHALL be ignored.

Reset
REQ-028 While resetn=0 on a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-029 During reset, req_ready SHALL be 0, and rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-030 All storage words SHALL clear to 0 during reset.
REQ-031 From the first edge with resetn=1, req_ready SHALL be 1.
REQ-032 Reset during WAIT or RESP SHALL abort the transaction with no response. A store in WAIT SHALL NOT commit.

Configuration
REQ-033 With DMEM_RESPONDER_MISALIGN_ERR_EN defined, these in-range requests SHALL give rsp_err=1 with no storage change:
- req_addr[1:0] != 0 with any load;
- req_addr[1:0] != 0 with a store whose wstrb is not 0001, 0010, 0100, 1000, 0011 or 1100.
REQ-034 Without the macro, req_addr[1:0] SHALL be ignored, and only out-of-range accesses SHALL set rsp_err.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the request-record struct (write, addr, wdata, wstrb) and the default-parameter constants.
REQ-036 Byte-lane merging SHALL be a sub-module, dmem_lane_merge (old word, wdata, wstrb -> new word).

Verification
REQ-037 Reset, then store addr 0x10, wdata 0xDEADBEEF, wstrb 1111, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 LATENCY=2: accept at cycle 5 -> rsp_valid rises in cycle 8. Hold rsp_ready=0 for 3 cycles -> response held stable and req_ready=0 throughout.
REQ-039 Store 0x00 = 0x11223344, then store 0x00 wdata 0xAABBCCDD wstrb 0101 -> load 0x00 returns 0x11BB33DD.
REQ-040 DEPTH_WORDS=256: load 0x400 -> rsp_err=1, rdata=0. Store to 0x400 followed by load 0x000 -> 0x000 unchanged.
REQ-041 Issue a store to 0x20, assert resetn=0 in WAIT -> FSM returns to IDLE, no response, load 0x20 returns 0.
REQ-042 With the macro, load 0x13 -> rsp_err=1. Without it, load 0x13 returns the word at 0x10 with rsp_err=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the single-outstanding data-memory responder:
// FSM states, the latched request record and the narrow-store lane check.
package dmem_responder_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_rec_t;

  // Byte and aligned-halfword strobes are the only shapes a misaligned store may use.
  function automatic logic narrow_strb_ok(input logic [3:0] wstrb);
    case (wstrb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: narrow_strb_ok = 1'b1;
      default:                                                narrow_strb_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane merge: each byte of the new word comes from wdata when its strobe
// bit is set, otherwise it keeps the old word's byte.
module dmem_lane_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] new_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign new_word[8*gi +: 8] = wstrb[gi] ? wdata[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with one outstanding request and a fixed LATENCY.
// Optional: define DMEM_RESPONDER_MISALIGN_ERR_EN to fault misaligned accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4      = 4'(LATENCY);
  localparam logic [31:0] ADDR_SPAN = 32'(4 * DEPTH_WORDS);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  req_rec_t    req_reg;
  req_rec_t    cur_rec;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic          accept;
  logic          enter_resp;
  logic          out_of_range;
  logic          misalign;
  logic          fault;
  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   merged_word;

  assign req_ready = resetn && (state_reg == IDLE);
  assign rsp_valid = resetn && (state_reg == RESP);
  assign rsp_rdata = rsp_valid ? rdata_reg : 32'd0;
  assign rsp_err   = rsp_valid && err_reg;
  assign accept    = req_valid && req_ready;

  // With LATENCY=0 the access happens on the accept edge itself, so the live
  // request is used while IDLE and the latched copy afterwards.
  always_comb begin
    cur_rec = req_reg;
    if (state_reg == IDLE) begin
      cur_rec.write = req_write;
      cur_rec.addr  = req_addr;
      cur_rec.wdata = req_wdata;
      cur_rec.wstrb = req_wstrb;
    end
  end

  assign idx          = cur_rec.addr[AW+1:2];
  assign old_word     = mem[idx];
  assign out_of_range = (cur_rec.addr >= ADDR_SPAN);

`ifdef DMEM_RESPONDER_MISALIGN_ERR_EN
  assign misalign = (cur_rec.addr[1:0] != 2'b00) &&
                    (!cur_rec.write || !narrow_strb_ok(cur_rec.wstrb));
`else
  assign misalign = 1'b0;
`endif

  assign fault = out_of_range || misalign;

  dmem_lane_merge u_lane_merge (
    .old_word (old_word),
    .wdata    (cur_rec.wdata),
    .wstrb    (cur_rec.wstrb),
    .new_word (merged_word)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT4;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_reg <= '0;
    end else if (accept) begin
      req_reg <= cur_rec;
    end
  end

  // Reset wins over a commit, so a store still in WAIT never lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (enter_resp && cur_rec.write && !fault) begin
      mem[idx] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else if (enter_resp) begin
      err_reg   <= fault;
      rdata_reg <= (cur_rec.write || fault) ? 32'd0 : old_word;
    end else if (state_reg == RESP && rsp_ready) begin
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end
  end

endmodule
